zp_axi_dram_burst_mover: RTL and testbench

//  Parametrised AXI4 master traffic engine for the dram-example PL design; sits behind the CSR block, drives m00_axi to PS DRAM.

---
 rtl/zp_dram_mover_pkg.sv | 19 +
 rtl/zp_burst_len_calc.sv | 25 ++
 rtl/zp_axi_dram_burst_mover.sv | 237 +++++++++++++++++++++++
 tb/tb_zp_axi_dram_burst_mover.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zp_dram_mover_pkg.sv
// Shared types and AXI constants for the DRAM burst mover.
package zp_dram_mover_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0]  AXI_CACHE      = 4'b0011;
  localparam logic [12:0] BOUNDARY_4K    = 13'd4096;

endpackage

// File: rtl/zp_burst_len_calc.sv
// Burst length: min(remaining beats, max burst, beats left before the next 4 KB boundary).
module zp_burst_len_calc
  import zp_dram_mover_pkg::*;
#(
  parameter int unsigned BW         = 16,
  parameter int unsigned BYTE_SHIFT = 3,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic [BW-1:0] remaining,
  input  logic [11:0]   addr_lo,
  output logic [8:0]    len
);

  logic [12:0] to_boundary;
  logic [31:0] rem_w;
  logic [31:0] lim;

  always_comb begin
    to_boundary = (BOUNDARY_4K - {1'b0, addr_lo}) >> BYTE_SHIFT;
    rem_w       = 32'(remaining);
    lim         = (32'(MAX_LEN) < 32'(to_boundary)) ? 32'(MAX_LEN) : 32'(to_boundary);
    len         = 9'((rem_w < lim) ? rem_w : lim);
  end

endmodule

// File: rtl/zp_axi_dram_burst_mover.sv
// AXI4 master: one write/read command split into 4 KB-safe INCR bursts, one outstanding.
// Optional read-data checking with ZP_DRAM_MOVER_CHECK_EN.
module zp_axi_dram_burst_mover
  import zp_dram_mover_pkg::*;
#(
  parameter int unsigned C_M00_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_M00_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M00_AXI_ID_WIDTH   = 6,
  parameter int unsigned C_MAX_BURST_LEN      = 16,
  parameter int unsigned C_BEATS_WIDTH        = 16
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              cmd_v_i,
  output logic                              cmd_ready_o,
  input  logic                              cmd_write_i,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [C_BEATS_WIDTH-1:0]          cmd_beats_i,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_seed_i,
  output logic                              done_o,
  output logic                              resp_err_o,
  output logic [C_BEATS_WIDTH-1:0]          beat_cnt_o,
`ifdef ZP_DRAM_MOVER_CHECK_EN
  output logic                              chk_err_o,
  output logic [C_BEATS_WIDTH-1:0]          chk_err_cnt_o,
`endif
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_ID_WIDTH-1:0]     m00_axi_awid,
  output logic [7:0]                        m00_axi_awlen,
  output logic [2:0]                        m00_axi_awsize,
  output logic [1:0]                        m00_axi_awburst,
  output logic                              m00_axi_awlock,
  output logic [3:0]                        m00_axi_awcache,
  output logic [2:0]                        m00_axi_awprot,
  output logic [3:0]                        m00_axi_awqos,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wlast,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic [C_M00_AXI_ID_WIDTH-1:0]     m00_axi_bid,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  output logic [C_M00_AXI_ID_WIDTH-1:0]     m00_axi_arid,
  output logic [7:0]                        m00_axi_arlen,
  output logic [2:0]                        m00_axi_arsize,
  output logic [1:0]                        m00_axi_arburst,
  output logic                              m00_axi_arlock,
  output logic [3:0]                        m00_axi_arcache,
  output logic [2:0]                        m00_axi_arprot,
  output logic [3:0]                        m00_axi_arqos,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic [C_M00_AXI_ID_WIDTH-1:0]     m00_axi_rid,
  input  logic                              m00_axi_rlast
);

  localparam int unsigned DW         = C_M00_AXI_DATA_WIDTH;
  localparam int unsigned AW         = C_M00_AXI_ADDR_WIDTH;
  localparam int unsigned BW         = C_BEATS_WIDTH;
  localparam int unsigned BYTE_SHIFT = $clog2(DW / 8);
  localparam logic [AW-1:0] ADDR_MASK = AW'((1 << BYTE_SHIFT) - 1);

  state_t          state, state_next;
  logic [AW-1:0]   addr, calc_addr;
  logic [BW-1:0]   rem, rem_after, calc_rem;
  logic [DW-1:0]   seed;
  logic [8:0]      burst_len, calc_len, beat;
  logic [BW-1:0]   beat_cnt;
  logic            resp_err;
  logic            accept, w_hs, r_hs, beat_end, last_burst, load_burst;

  assign accept     = cmd_v_i && (state == S_IDLE);
  assign w_hs       = m00_axi_wvalid && m00_axi_wready;
  assign r_hs       = m00_axi_rready && m00_axi_rvalid;
  assign beat_end   = (beat == burst_len - 9'd1);
  assign rem_after  = rem - BW'(burst_len);
  assign last_burst = (rem_after == '0);

  // In IDLE the calculator sees the incoming command; otherwise it sees the burst after the current one.
  assign calc_addr = (state == S_IDLE) ? (cmd_addr_i & ~ADDR_MASK)
                                       : (addr + (AW'(burst_len) << BYTE_SHIFT));
  assign calc_rem  = (state == S_IDLE) ? cmd_beats_i : rem_after;
  assign load_burst = ((state_next == S_AW) && (state != S_AW)) ||
                      ((state_next == S_AR) && (state != S_AR));

  zp_burst_len_calc #(
    .BW         (BW),
    .BYTE_SHIFT (BYTE_SHIFT),
    .MAX_LEN    (C_MAX_BURST_LEN)
  ) u_len_calc (
    .remaining (calc_rem),
    .addr_lo   (calc_addr[11:0]),
    .len       (calc_len)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    cmd_ready_o     = 1'b0;
    done_o          = 1'b0;
    m00_axi_awvalid = 1'b0;
    m00_axi_wvalid  = 1'b0;
    m00_axi_wlast   = 1'b0;
    m00_axi_bready  = 1'b0;
    m00_axi_arvalid = 1'b0;
    m00_axi_rready  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (accept) begin
          if (cmd_beats_i == '0) state_next = S_DONE;
          else                   state_next = cmd_write_i ? S_AW : S_AR;
        end
      end
      S_AW: begin
        m00_axi_awvalid = 1'b1;
        if (m00_axi_awready) state_next = S_W;
      end
      S_W: begin
        m00_axi_wvalid = 1'b1;
        m00_axi_wlast  = beat_end;
        if (m00_axi_wready && beat_end) state_next = S_B;
      end
      S_B: begin
        m00_axi_bready = 1'b1;
        if (m00_axi_bvalid) state_next = last_burst ? S_DONE : S_AW;
      end
      S_AR: begin
        m00_axi_arvalid = 1'b1;
        if (m00_axi_arready) state_next = S_R;
      end
      S_R: begin
        m00_axi_rready = 1'b1;
        if (m00_axi_rvalid && (m00_axi_rlast || beat_end))
          state_next = last_burst ? S_DONE : S_AR;
      end
      S_DONE:  begin
        done_o     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr      <= '0;
      rem       <= '0;
      seed      <= '0;
      burst_len <= '0;
      beat      <= '0;
      beat_cnt  <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        seed     <= cmd_seed_i;
        beat_cnt <= '0;
        resp_err <= 1'b0;
      end
      if (load_burst) begin
        addr      <= calc_addr;
        rem       <= calc_rem;
        burst_len <= calc_len;
        beat      <= '0;
      end
      if (w_hs || r_hs) begin
        beat     <= beat + 9'd1;
        beat_cnt <= beat_cnt + BW'(1);
      end
      if ((m00_axi_bready && m00_axi_bvalid && (m00_axi_bresp != AXI_RESP_OKAY)) ||
          (r_hs && (m00_axi_rresp != AXI_RESP_OKAY)))
        resp_err <= 1'b1;
    end
  end

  assign beat_cnt_o      = beat_cnt;
  assign resp_err_o      = resp_err;
  assign m00_axi_wdata   = seed + DW'(beat_cnt);
  assign m00_axi_wstrb   = '1;
  assign m00_axi_awaddr  = addr;
  assign m00_axi_awid    = '0;
  assign m00_axi_awlen   = 8'(burst_len - 9'd1);
  assign m00_axi_awsize  = 3'(BYTE_SHIFT);
  assign m00_axi_awburst = AXI_BURST_INCR;
  assign m00_axi_awlock  = 1'b0;
  assign m00_axi_awcache = AXI_CACHE;
  assign m00_axi_awprot  = '0;
  assign m00_axi_awqos   = '0;
  assign m00_axi_araddr  = addr;
  assign m00_axi_arid    = '0;
  assign m00_axi_arlen   = 8'(burst_len - 9'd1);
  assign m00_axi_arsize  = 3'(BYTE_SHIFT);
  assign m00_axi_arburst = AXI_BURST_INCR;
  assign m00_axi_arlock  = 1'b0;
  assign m00_axi_arcache = AXI_CACHE;
  assign m00_axi_arprot  = '0;
  assign m00_axi_arqos   = '0;

  logic unused_ok;
`ifdef ZP_DRAM_MOVER_CHECK_EN
  logic          chk_err;
  logic [BW-1:0] chk_cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      chk_err <= 1'b0;
      chk_cnt <= '0;
    end else if (accept) begin
      chk_err <= 1'b0;
      chk_cnt <= '0;
    end else if (r_hs && (m00_axi_rdata != (seed + DW'(beat_cnt)))) begin
      chk_err <= 1'b1;
      if (chk_cnt != '1) chk_cnt <= chk_cnt + BW'(1);
    end
  end

  assign chk_err_o     = chk_err;
  assign chk_err_cnt_o = chk_cnt;
  assign unused_ok     = &{1'b0, m00_axi_bid, m00_axi_rid};
`else
  assign unused_ok     = &{1'b0, m00_axi_bid, m00_axi_rid, m00_axi_rdata};
`endif

endmodule

// File: tb/tb_zp_axi_dram_burst_mover.sv
// Directed bench for zp_axi_dram_burst_mover with a simple single-outstanding AXI slave.
module tb_zp_axi_dram_burst_mover;

  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int IDW = 6;
  localparam int BW  = 16;
  localparam int LOG = 512;

  logic            aclk = 1'b0;
  logic            areset;
  logic            cmd_v, cmd_write, cmd_ready_o, done_o, resp_err_o;
  logic [AW-1:0]   cmd_addr;
  logic [BW-1:0]   cmd_beats, beat_cnt_o;
  logic [DW-1:0]   cmd_seed;
`ifdef ZP_DRAM_MOVER_CHECK_EN
  logic            chk_err;
  logic [BW-1:0]   chk_err_cnt;
`endif
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, awlock, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, arlock, rvalid, rready, rlast;
  logic [IDW-1:0]  awid, arid;
  logic [IDW-1:0]  bid = '0;
  logic [IDW-1:0]  rid = '0;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize, awprot, arprot;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic [3:0]      awcache, arcache, awqos, arqos;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;

  int n_cmp = 0;
  int n_err = 0;

  // slave configuration (written by the stimulus process only)
  bit bp_en = 0;
  int err_b_at = -1;
  int corrupt_at = -1;
  int r_start = 0;
  logic [DW-1:0] r_seed = '0;

  // slave state and logs (written by the slave process only)
  int aw_n = 0, w_n = 0, ar_n = 0, done_cnt = 0, b_total = 0, r_total = 0;
  int pend_b = 0, r_beat = 0, r_len = 0;
  bit r_act = 0;
  logic [AW-1:0] aw_addr_log [LOG];
  logic [7:0]    aw_len_log  [LOG];
  logic [AW-1:0] ar_addr_log [LOG];
  logic [7:0]    ar_len_log  [LOG];
  logic [DW-1:0] w_data_log  [LOG];
  logic          w_last_log  [LOG];

  always #5 aclk = ~aclk;

  zp_axi_dram_burst_mover #(
    .C_M00_AXI_DATA_WIDTH (DW),
    .C_M00_AXI_ADDR_WIDTH (AW),
    .C_M00_AXI_ID_WIDTH   (IDW),
    .C_MAX_BURST_LEN      (16),
    .C_BEATS_WIDTH        (BW)
  ) dut (
    .aclk (aclk), .areset (areset),
    .cmd_v_i (cmd_v), .cmd_ready_o (cmd_ready_o), .cmd_write_i (cmd_write),
    .cmd_addr_i (cmd_addr), .cmd_beats_i (cmd_beats), .cmd_seed_i (cmd_seed),
    .done_o (done_o), .resp_err_o (resp_err_o), .beat_cnt_o (beat_cnt_o),
`ifdef ZP_DRAM_MOVER_CHECK_EN
    .chk_err_o (chk_err), .chk_err_cnt_o (chk_err_cnt),
`endif
    .m00_axi_awaddr (awaddr), .m00_axi_awvalid (awvalid), .m00_axi_awready (awready),
    .m00_axi_awid (awid), .m00_axi_awlen (awlen), .m00_axi_awsize (awsize),
    .m00_axi_awburst (awburst), .m00_axi_awlock (awlock), .m00_axi_awcache (awcache),
    .m00_axi_awprot (awprot), .m00_axi_awqos (awqos),
    .m00_axi_wdata (wdata), .m00_axi_wstrb (wstrb), .m00_axi_wlast (wlast),
    .m00_axi_wvalid (wvalid), .m00_axi_wready (wready),
    .m00_axi_bvalid (bvalid), .m00_axi_bready (bready), .m00_axi_bresp (bresp), .m00_axi_bid (bid),
    .m00_axi_araddr (araddr), .m00_axi_arvalid (arvalid), .m00_axi_arready (arready),
    .m00_axi_arid (arid), .m00_axi_arlen (arlen), .m00_axi_arsize (arsize),
    .m00_axi_arburst (arburst), .m00_axi_arlock (arlock), .m00_axi_arcache (arcache),
    .m00_axi_arprot (arprot), .m00_axi_arqos (arqos),
    .m00_axi_rdata (rdata), .m00_axi_rvalid (rvalid), .m00_axi_rready (rready),
    .m00_axi_rresp (rresp), .m00_axi_rid (rid), .m00_axi_rlast (rlast)
  );

  // Slave: drives for the coming cycle on each falling edge, then logs the handshakes they produce.
  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
    rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        pend_b = 0; r_act = 0; r_beat = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
      end else begin
        awready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
        wready  = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
        arready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
        bvalid  = (pend_b != 0);
        bresp   = (b_total == err_b_at) ? 2'b10 : 2'b00;
        rvalid  = r_act && (bp_en ? 1'($urandom_range(1, 0)) : 1'b1);
        rdata   = r_seed + DW'(r_total - r_start);
        if (r_total == corrupt_at) rdata = rdata ^ DW'(8'hA5);
        rlast   = (r_beat == r_len);
        rresp   = 2'b00;
        if (done_o) done_cnt++;
        if (awvalid && awready) begin
          aw_addr_log[aw_n] = awaddr; aw_len_log[aw_n] = awlen; aw_n++;
        end
        if (wvalid && wready) begin
          w_data_log[w_n] = wdata; w_last_log[w_n] = wlast; w_n++;
          if (wlast) pend_b++;
        end
        if (bvalid && bready) begin
          pend_b--; b_total++;
        end
        if (rvalid && rready) begin
          r_total++;
          if (r_beat == r_len) r_act = 0;
          else r_beat++;
        end
        if (arvalid && arready) begin
          ar_addr_log[ar_n] = araddr; ar_len_log[ar_n] = arlen; ar_n++;
          r_act = 1; r_beat = 0; r_len = int'(arlen);
        end
      end
    end
  end

  task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] n,
                         input logic [DW-1:0] s, output logic to);
    int d0;
    d0 = done_cnt;
    @(negedge aclk);
    cmd_v = 1; cmd_write = wr; cmd_addr = a; cmd_beats = n; cmd_seed = s;
    for (int i = 0; i < 100 && !cmd_ready_o; i++) @(negedge aclk);
    @(negedge aclk);
    cmd_v = 0;
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(negedge aclk);
    to = (done_cnt == d0);
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_reset;
    areset = 1; cmd_v = 0; cmd_write = 0; cmd_addr = '0; cmd_beats = '0; cmd_seed = '0;
    repeat (2) @(negedge aclk);
    n_cmp++;
    if ({cmd_ready_o, awvalid, wvalid, bready, arvalid, rready, done_o, resp_err_o} !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 10000000",
               {cmd_ready_o, awvalid, wvalid, bready, arvalid, rready, done_o, resp_err_o});
    end
    n_cmp++;
    if (beat_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt_o); end
    n_cmp++;
    if ({awsize, awburst, awcache, awlock, awid, arsize, arburst, arcache, wstrb} !==
        {3'd3, 2'b01, 4'b0011, 1'b0, 6'd0, 3'd3, 2'b01, 4'b0011, 8'hFF}) begin
      n_err++;
      $display("FAIL const_fields: got %h want %h", {awsize, awburst, awcache, awlock, awid, arsize, arburst, arcache, wstrb},
               {3'd3, 2'b01, 4'b0011, 1'b0, 6'd0, 3'd3, 2'b01, 4'b0011, 8'hFF});
    end
    areset = 0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_write8;
    int aw0, w0, d0;
    logic to;
    aw0 = aw_n; w0 = w_n; d0 = done_cnt;
    run_cmd(1, 32'h1000, 16'd8, 64'h10, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL w8_timeout: got timeout want done"); end
    n_cmp++;
    if (aw_n - aw0 != 1 || aw_addr_log[aw0] !== 32'h1000 || aw_len_log[aw0] !== 8'd7) begin
      n_err++;
      $display("FAIL w8_aw: got n=%0d addr=%h len=%0d want n=1 addr=1000 len=7", aw_n - aw0, aw_addr_log[aw0], aw_len_log[aw0]);
    end
    n_cmp++; if (w_n - w0 != 8) begin n_err++; $display("FAIL w8_wcount: got %0d want 8", w_n - w0); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (w_data_log[w0+k] !== 64'h10 + 64'(k) || w_last_log[w0+k] !== (k == 7)) begin
        n_err++;
        $display("FAIL w8_beat%0d: got data=%h last=%b want data=%h last=%b", k, w_data_log[w0+k], w_last_log[w0+k], 64'h10 + 64'(k), k == 7);
      end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL w8_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (beat_cnt_o !== 16'd8) begin n_err++; $display("FAIL w8_beat_cnt: got %0d want 8", beat_cnt_o); end
  endtask

  task automatic test_align;
    int aw0, w0;
    logic to;
    aw0 = aw_n; w0 = w_n;
    run_cmd(1, 32'h2005, 16'd2, 64'h7, to);
    n_cmp++;
    if (to || aw_addr_log[aw0] !== 32'h2000 || aw_len_log[aw0] !== 8'd1) begin
      n_err++;
      $display("FAIL align_aw: got to=%b addr=%h len=%0d want to=0 addr=2000 len=1", to, aw_addr_log[aw0], aw_len_log[aw0]);
    end
    n_cmp++;
    if (w_data_log[w0] !== 64'h7 || w_data_log[w0+1] !== 64'h8) begin
      n_err++;
      $display("FAIL align_data: got %h,%h want 7,8", w_data_log[w0], w_data_log[w0+1]);
    end
  endtask

  task automatic test_write40;
    int aw0, w0, d0;
    logic to;
    logic [AW-1:0] ea [3];
    logic [7:0]    el [3];
    ea[0] = 32'h0; ea[1] = 32'h80; ea[2] = 32'h100;
    el[0] = 8'd15; el[1] = 8'd15; el[2] = 8'd7;
    aw0 = aw_n; w0 = w_n; d0 = done_cnt;
    run_cmd(1, 32'h0, 16'd40, 64'h1000, to);
    n_cmp++;
    if (to || aw_n - aw0 != 3) begin n_err++; $display("FAIL w40_aw_n: got to=%b n=%0d want to=0 n=3", to, aw_n - aw0); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (aw_addr_log[aw0+i] !== ea[i] || aw_len_log[aw0+i] !== el[i]) begin
        n_err++;
        $display("FAIL w40_aw%0d: got addr=%h len=%0d want addr=%h len=%0d", i, aw_addr_log[aw0+i], aw_len_log[aw0+i], ea[i], el[i]);
      end
    end
    n_cmp++;
    if (w_n - w0 != 40 || w_data_log[w0+39] !== 64'h1027 ||
        {w_last_log[w0+15], w_last_log[w0+31], w_last_log[w0+39], w_last_log[w0+14]} !== 4'b1110) begin
      n_err++;
      $display("FAIL w40_w: got n=%0d last_data=%h lasts=%b want n=40 last_data=1027 lasts=1110", w_n - w0, w_data_log[w0+39],
               {w_last_log[w0+15], w_last_log[w0+31], w_last_log[w0+39], w_last_log[w0+14]});
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || beat_cnt_o !== 16'd40) begin
      n_err++;
      $display("FAIL w40_done: got pulses=%0d beat_cnt=%0d want 1 40", done_cnt - d0, beat_cnt_o);
    end
  endtask

  task automatic test_read_4k;
    int ar0, aw0;
    logic to;
    ar0 = ar_n; aw0 = aw_n;
    r_seed = 64'h500; r_start = r_total;
    run_cmd(0, 32'hFF0, 16'd4, 64'h500, to);
    n_cmp++;
    if (to || ar_n - ar0 != 2 || aw_n != aw0) begin
      n_err++;
      $display("FAIL r4k_count: got to=%b ar=%0d aw=%0d want to=0 ar=2 aw=0", to, ar_n - ar0, aw_n - aw0);
    end
    n_cmp++;
    if (ar_addr_log[ar0] !== 32'hFF0 || ar_len_log[ar0] !== 8'd1 ||
        ar_addr_log[ar0+1] !== 32'h1000 || ar_len_log[ar0+1] !== 8'd1) begin
      n_err++;
      $display("FAIL r4k_split: got %h/%0d %h/%0d want ff0/1 1000/1", ar_addr_log[ar0], ar_len_log[ar0], ar_addr_log[ar0+1], ar_len_log[ar0+1]);
    end
    n_cmp++; if (beat_cnt_o !== 16'd4) begin n_err++; $display("FAIL r4k_beat_cnt: got %0d want 4", beat_cnt_o); end
  endtask

  task automatic test_zero_beats;
    int aw0, ar0, d0;
    logic d1, d2, rdy2;
    aw0 = aw_n; ar0 = ar_n; d0 = done_cnt;
    @(negedge aclk);
    cmd_v = 1; cmd_write = 1; cmd_addr = 32'h9000; cmd_beats = '0;
    @(negedge aclk);
    cmd_v = 0; d1 = done_o;
    @(negedge aclk);
    d2 = done_o; rdy2 = cmd_ready_o;
    repeat (4) @(negedge aclk);
    n_cmp++;
    if ({d1, d2, rdy2} !== 3'b101) begin n_err++; $display("FAIL zero_done_timing: got %b want 101", {d1, d2, rdy2}); end
    n_cmp++;
    if (aw_n != aw0 || ar_n != ar0 || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL zero_no_axi: got aw=%0d ar=%0d pulses=%0d want 0 0 1", aw_n - aw0, ar_n - ar0, done_cnt - d0);
    end
  endtask

  task automatic test_slverr;
    int aw0;
    logic to;
    aw0 = aw_n;
    err_b_at = b_total + 1;
    run_cmd(1, 32'h4000, 16'd40, 64'h0, to);
    n_cmp++;
    if (to || resp_err_o !== 1'b1 || beat_cnt_o !== 16'd40 || aw_n - aw0 != 3) begin
      n_err++;
      $display("FAIL slverr_sticky: got to=%b err=%b beats=%0d aw=%0d want 0 1 40 3", to, resp_err_o, beat_cnt_o, aw_n - aw0);
    end
    err_b_at = -1;
    run_cmd(1, 32'h5000, 16'd1, 64'h0, to);
    n_cmp++;
    if (to || resp_err_o !== 1'b0) begin n_err++; $display("FAIL slverr_clear: got to=%b err=%b want 0 0", to, resp_err_o); end
  endtask

  task automatic test_backpressure;
    int aw0, w0, ar0, bad;
    logic to;
    bp_en = 1;
    aw0 = aw_n; w0 = w_n; ar0 = ar_n;
    run_cmd(1, 32'h3000, 16'd20, 64'h100, to);
    n_cmp++;
    if (to || aw_n - aw0 != 2 || aw_addr_log[aw0+1] !== 32'h3080 || aw_len_log[aw0] !== 8'd15 || aw_len_log[aw0+1] !== 8'd3) begin
      n_err++;
      $display("FAIL bp_write_aw: got to=%b n=%0d addr1=%h lens=%0d,%0d want 0 2 3080 15,3", to, aw_n - aw0, aw_addr_log[aw0+1], aw_len_log[aw0], aw_len_log[aw0+1]);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) if (w_data_log[w0+k] !== 64'h100 + 64'(k)) bad++;
    n_cmp++;
    if (bad != 0 || w_n - w0 != 20) begin n_err++; $display("FAIL bp_write_data: got %0d bad of %0d want 0 of 20", bad, w_n - w0); end
    r_seed = 64'h100; r_start = r_total;
    run_cmd(0, 32'h3000, 16'd20, 64'h100, to);
    n_cmp++;
    if (to || ar_n - ar0 != 2 || ar_len_log[ar0] !== 8'd15 || ar_len_log[ar0+1] !== 8'd3 || beat_cnt_o !== 16'd20 || resp_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_read: got to=%b ar=%0d lens=%0d,%0d beats=%0d err=%b want 0 2 15,3 20 0", to, ar_n - ar0, ar_len_log[ar0], ar_len_log[ar0+1], beat_cnt_o, resp_err_o);
    end
`ifdef ZP_DRAM_MOVER_CHECK_EN
    n_cmp++;
    if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_clean: got %b want 0", chk_err); end
    r_start = r_total; corrupt_at = r_total + 3;
    run_cmd(0, 32'h3000, 16'd8, 64'h100, to);
    n_cmp++;
    if (to || chk_err !== 1'b1 || chk_err_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL chk_corrupt: got to=%b err=%b cnt=%0d want 0 1 1", to, chk_err, chk_err_cnt);
    end
    corrupt_at = -1; r_start = r_total;
    run_cmd(0, 32'h3000, 16'd2, 64'h100, to);
    n_cmp++;
    if (to || chk_err !== 1'b0 || chk_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL chk_clear: got to=%b err=%b cnt=%0d want 0 0 0", to, chk_err, chk_err_cnt);
    end
`endif
    bp_en = 0;
  endtask

  task automatic test_reset_mid;
    int w0, aw0;
    logic to;
    w0 = w_n;
    @(negedge aclk);
    cmd_v = 1; cmd_write = 1; cmd_addr = 32'h6000; cmd_beats = 16'd40; cmd_seed = '0;
    @(negedge aclk);
    cmd_v = 0;
    for (int i = 0; i < 200 && (w_n - w0) < 3; i++) @(negedge aclk);
    n_cmp++;
    if (w_n - w0 < 3 || wvalid !== 1'b1) begin n_err++; $display("FAIL mid_reach_w: got beats=%0d wvalid=%b want >=3 1", w_n - w0, wvalid); end
    areset = 1;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, bready, arvalid, rready, cmd_ready_o, done_o} !== 7'b0000010 || beat_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset_drop: got %b beats=%0d want 0000010 0", {awvalid, wvalid, bready, arvalid, rready, cmd_ready_o, done_o}, beat_cnt_o);
    end
    repeat (2) @(negedge aclk);
    areset = 0;
    repeat (2) @(negedge aclk);
    aw0 = aw_n;
    run_cmd(1, 32'h7000, 16'd2, 64'h0, to);
    n_cmp++;
    if (to || aw_addr_log[aw0] !== 32'h7000 || aw_len_log[aw0] !== 8'd1 || beat_cnt_o !== 16'd2) begin
      n_err++;
      $display("FAIL mid_recover: got to=%b addr=%h len=%0d beats=%0d want 0 7000 1 2", to, aw_addr_log[aw0], aw_len_log[aw0], beat_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_write8();
    test_align();
    test_write40();
    test_read_4k();
    test_zero_beats();
    test_slverr();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish within 2ms");
    $fatal(1);
  end

endmodule
